// File: rtl/dense_layer_sequencer.sv
// Control sequencer for one fully-connected layer: loads N_IN activations, runs
// N_OUT/LANES neuron groups through the MAC lanes, then drains the results.
module dense_layer_sequencer #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 10,
    parameter int LANES  = 1,
    parameter int IN_AW  = 10,
    parameter int OUT_AW = 4,
    parameter int W_AW   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              relu,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              in_we,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              mac_bias,
    output logic              relu_q,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_grp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_AW-1:0] out_addr,
    output logic              out_last
);
    localparam int N_GRP = N_OUT / LANES;
    localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] G_LAST = OUT_AW'(N_GRP - 1);
    localparam logic [OUT_AW-1:0] O_LAST = OUT_AW'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_MAC, S_BIAS, S_WB, S_DRAIN
    } state_t;

    state_t            state_reg, state_next;
    logic [IN_AW-1:0]  i_reg, i_next;
    logic [OUT_AW-1:0] grp_reg, grp_next;
    logic [OUT_AW-1:0] o_reg, o_next;
    logic              relu_reg, relu_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            i_reg     <= '0;
            grp_reg   <= '0;
            o_reg     <= '0;
            relu_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            grp_reg   <= grp_next;
            o_reg     <= o_next;
            relu_reg  <= relu_next;
        end
    end

    assign relu_q = relu_reg;

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        grp_next   = grp_reg;
        o_next     = o_reg;
        relu_next  = relu_reg;
        busy       = (state_reg != S_IDLE);
        done       = 1'b0;
        in_ready   = 1'b0;
        in_we      = 1'b0;
        in_addr    = '0;
        w_addr     = '0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        mac_bias   = 1'b0;
        out_we     = 1'b0;
        out_grp    = '0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_last   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    relu_next  = relu;
                    i_next     = '0;
                    grp_next   = '0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                in_addr  = i_reg;
                if (in_valid) begin
                    in_we = 1'b1;
                    if (i_reg == I_LAST) begin
                        i_next     = '0;
                        state_next = S_CLR;
                    end else begin
                        i_next = i_reg + 1'b1;
                    end
                end
            end
            S_CLR: begin
                mac_clear  = 1'b1;
                i_next     = '0;
                state_next = S_MAC;
            end
            S_MAC: begin
                mac_en  = 1'b1;
                in_addr = i_reg;
                // Weight rows are laid out group-major: N_IN rows per group.
                w_addr  = W_AW'(grp_reg) * W_AW'(N_IN) + W_AW'(i_reg);
                if (i_reg == I_LAST) begin
                    i_next     = '0;
                    state_next = S_BIAS;
                end else begin
                    i_next = i_reg + 1'b1;
                end
            end
            S_BIAS: begin
                mac_en     = 1'b1;
                mac_bias   = 1'b1;
                w_addr     = W_AW'(grp_reg);
                state_next = S_WB;
            end
            S_WB: begin
                out_we  = 1'b1;
                out_grp = grp_reg;
                if (grp_reg == G_LAST) begin
                    o_next     = '0;
                    state_next = S_DRAIN;
                end else begin
                    grp_next   = grp_reg + 1'b1;
                    state_next = S_CLR;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_addr  = o_reg;
                out_last  = (o_reg == O_LAST);
                if (out_ready) begin
                    if (o_reg == O_LAST) begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        o_next = o_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: random handshakes, event traces compared with
// the expected layer schedule built from plain loops.
module tb_dense_layer_sequencer;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 4;
    localparam int LANES  = 2;
    localparam int IN_AW  = 3;
    localparam int OUT_AW = 3;
    localparam int W_AW   = 4;
    localparam int N_GRP  = N_OUT / LANES;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst, start, relu, in_valid, out_ready;
    logic busy, done, in_ready, in_we, mac_clear, mac_en, mac_bias, relu_q;
    logic out_we, out_valid, out_last;
    logic [IN_AW-1:0]  in_addr;
    logic [W_AW-1:0]   w_addr;
    logic [OUT_AW-1:0] out_grp, out_addr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dense_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES),
        .IN_AW(IN_AW), .OUT_AW(OUT_AW), .W_AW(W_AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .relu(relu), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_addr(in_addr),
        .w_addr(w_addr), .mac_clear(mac_clear), .mac_en(mac_en), .mac_bias(mac_bias),
        .relu_q(relu_q), .out_we(out_we), .out_grp(out_grp), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_in_we"}, in_we, 0);
        chk({tag, "_in_addr"}, in_addr, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_mac_clear"}, mac_clear, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_mac_bias"}, mac_bias, 0);
        chk({tag, "_relu_q"}, relu_q, 0);
        chk({tag, "_out_we"}, out_we, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_out_last"}, out_last, 0);
    endtask

    // vp < 0 selects a strict 1,0,1,0 in_valid pattern; otherwise a percentage.
    task automatic run_inf(input bit do_start, input bit hold, input bit relu_v,
                           input int vp, input int rp, input bit stall);
        int  in_q[$];
        int  ev_q[$];
        int  mi_q[$];
        int  hs_q[$];
        int  exp_ev[$];
        int  cyc = 0;
        int  last_we = -1;
        int  first_v = -1;
        int  stall_cnt = 0;
        int  done_cnt = 0;
        bit  fin = 0;
        bit  forced;
        if (do_start) begin
            start = 1'b1;
            relu  = relu_v;
        end
        while (!fin && cyc < BUDGET) begin
            in_valid = (vp < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < vp);
            forced = stall && out_valid && out_addr == 2 && stall_cnt < 3;
            if (forced) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = ($urandom_range(99) < rp);
            end
            @(negedge clk);
            if (busy) chk("relu_q_held", relu_q, relu_v);
            if (in_we) begin
                in_q.push_back(int'(in_addr));
                last_we = cyc;
            end
            if (mac_clear) ev_q.push_back(1000);
            if (mac_en && !mac_bias) begin
                ev_q.push_back(int'(w_addr));
                mi_q.push_back(int'(in_addr));
            end
            if (mac_bias) ev_q.push_back(2000);
            if (out_we) ev_q.push_back(3000 + int'(out_grp));
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid) chk("out_last", out_last, out_addr == N_OUT - 1);
            if (out_valid && out_ready) hs_q.push_back(int'(out_addr));
            if (forced) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_addr", out_addr, 2);
                chk("stall_no_done", done, 0);
            end
            if (done) begin
                done_cnt++;
                chk("done_on_last_hs", out_valid && out_ready && out_addr == N_OUT - 1, 1);
                fin = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) start = $urandom_range(1);
            relu = $urandom_range(1);
        end
        if (!hold) start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        if (stall) chk("stall_seen", stall_cnt, 3);

        chk("in_count", in_q.size(), N_IN);
        foreach (in_q[k]) if (k < N_IN) chk("in_addr_seq", in_q[k], k);

        for (int g = 0; g < N_GRP; g++) begin
            exp_ev.push_back(1000);
            for (int k = 0; k < N_IN; k++) exp_ev.push_back(g * N_IN + k);
            exp_ev.push_back(2000);
            exp_ev.push_back(3000 + g);
        end
        chk("ev_count", ev_q.size(), exp_ev.size());
        foreach (ev_q[k]) if (k < exp_ev.size()) chk("ev_seq", ev_q[k], exp_ev[k]);

        chk("mac_rd_count", mi_q.size(), N_GRP * N_IN);
        foreach (mi_q[k]) chk("mac_rd_addr", mi_q[k], k % N_IN);

        chk("hs_count", hs_q.size(), N_OUT);
        foreach (hs_q[k]) if (k < N_OUT) chk("hs_addr", hs_q[k], k);

        chk("done_count", done_cnt, 1);
        chk("latency", first_v - last_we - 1, N_GRP * (N_IN + 3));
        $display("[TB] inference relu=%0d vp=%0d rp=%0d cycles=%0d in=%0d ev=%0d out=%0d",
                 relu_v, vp, rp, cyc, in_q.size(), ev_q.size(), hs_q.size());
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; relu = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_inf(1, 0, 0, 100, 100, 0);
        run_inf(1, 0, 1, -1, 100, 0);
        run_inf(1, 0, 0, 70, 60, 1);
        run_inf(1, 0, 1, 60, 70, 0);
        run_inf(1, 0, 0, 50, 50, 0);

        // Reset in the middle of MAC, then a clean inference.
        start = 1'b1; relu = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int n = 0;
            while (!(mac_en && !mac_bias && in_addr == 2) && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("reach_mac_i2", n < 50, 1);
        end
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        run_inf(1, 0, 0, 75, 75, 0);

        // start held high through done: IDLE for one cycle, then LOAD again.
        run_inf(1, 1, 1, 80, 80, 0);
        relu = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_reload_busy", busy, 1);
        chk("hold_reload_in_ready", in_ready, 1);
        start = 1'b0;
        @(posedge clk);
        #1;
        run_inf(0, 0, 1, 65, 65, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
